dm_sram_responder: RTL and testbench

- Responder side of the CPU data-memory port: accepts the single-cycle, zero-wait DM_OE/DM_A/DM_WEB/DM_DI interface and returns DM_DO in the same cycle.
- Backs most of the word space with a byte-writable RAM array.
- Decodes the top four words as MMIO:
  - a 64-bit cycle counter with coherent high-half snapshot;
  - a console TX FIFO drained by an external valid/ready sink;
  - a sticky halt register.
- Instantiated beside the CPU in the top-level and testbench.

---
 rtl/dm_sram_responder.sv | 153 +++++++++++++++
 tb/tb_dm_sram_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sram_responder.sv
// ============================================================================
// Module   : dm_sram_responder
// Brief    : Zero-wait data-memory responder with byte-lane RAM and MMIO words
//            for a 64-bit cycle counter, console TX FIFO and sticky halt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_sram_responder #(
   parameter int DM_DEPTH   = 16384,
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        DM_OE,
   input  logic [$clog2(DM_DEPTH)-1:0] DM_A,
   input  logic [3:0]                  DM_WEB,
   input  logic [DATA_WIDTH-1:0]       DM_DI,
   output logic [DATA_WIDTH-1:0]       DM_DO,
   output logic                        con_valid,
   output logic [7:0]                  con_data,
   input  logic                        con_ready,
   output logic                        halt_o,
   output logic [DATA_WIDTH-1:0]       halt_code_o
);

   localparam int c_addr_w    = $clog2(DM_DEPTH);
   localparam int c_ram_words = DM_DEPTH - 4;
   localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w     = c_ptr_w + 1;

   localparam logic [c_addr_w-1:0] c_a_cyc_lo  = c_addr_w'(DM_DEPTH - 4);
   localparam logic [c_addr_w-1:0] c_a_cyc_hi  = c_addr_w'(DM_DEPTH - 3);
   localparam logic [c_addr_w-1:0] c_a_console = c_addr_w'(DM_DEPTH - 2);
   localparam logic [c_addr_w-1:0] c_a_halt    = c_addr_w'(DM_DEPTH - 1);
   localparam logic [c_cnt_w-1:0]  c_fifo_full = c_cnt_w'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [c_ram_words];
   logic [7:0]            r_fifo [FIFO_DEPTH];

   logic [63:0]           r_cyc;
   logic [31:0]           r_shadow_hi;
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_cnt_w-1:0]    r_count;
   logic                  r_ovf;
   logic                  r_halt;
   logic [DATA_WIDTH-1:0] r_halt_code;

   logic                  w_sel_ram;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_con_wr;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_ovf_set;
   logic                  w_ovf_clr;
   logic                  w_halt_wr;
   logic [7:0]            w_cnt8;
   logic [31:0]           w_con_status;

   assign w_sel_ram = (DM_A < c_a_cyc_lo);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_fifo_full);
   assign w_pop     = !w_empty && con_ready;
   assign w_con_wr  = (DM_A == c_a_console) && !DM_WEB[0];
   // A pop on the same edge frees a slot, so a push into a full FIFO is accepted.
   assign w_push    = w_con_wr && (!w_full || w_pop);
   assign w_ovf_set = w_con_wr && w_full && !w_pop;
   assign w_ovf_clr = DM_OE && (DM_A == c_a_console);
   assign w_halt_wr = (DM_A == c_a_halt) && (DM_WEB != 4'hF) && !r_halt;

   assign w_cnt8       = 8'(r_count);
   assign w_con_status = {16'h0, w_cnt8, 5'b0, r_ovf, w_empty, w_full};

   assign con_valid   = !w_empty;
   assign con_data    = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
   assign halt_o      = r_halt;
   assign halt_code_o = r_halt_code;

   // Storage arrays are intentionally unreset.
   always_ff @(posedge clk) begin
      if (w_sel_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (!DM_WEB[i]) begin
               r_mem[DM_A][8*i +: 8] <= DM_DI[8*i +: 8];
            end
         end
      end
      if (w_push) begin
         r_fifo[r_wr_ptr] <= DM_DI[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cyc       <= '0;
         r_shadow_hi <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_halt      <= 1'b0;
         r_halt_code <= '0;
      end else begin
         r_cyc <= r_cyc + 64'd1;
         if (DM_OE && (DM_A == c_a_cyc_lo)) begin
            r_shadow_hi <= r_cyc[63:32];
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_halt_wr) begin
            r_halt      <= 1'b1;
            r_halt_code <= DM_DI;
         end
      end
   end

   always_comb begin
      DM_DO = '0;
      if (DM_OE) begin
         if (w_sel_ram) begin
            DM_DO = r_mem[DM_A];
         end else begin
            case (DM_A)
               c_a_cyc_lo:  DM_DO = r_cyc[31:0];
               c_a_cyc_hi:  DM_DO = r_shadow_hi;
               c_a_console: DM_DO = w_con_status;
               c_a_halt:    DM_DO = {31'b0, r_halt};
               default:     DM_DO = '0;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dm_sram_responder.sv
// ============================================================================
// Module   : tb_dm_sram_responder
// Brief    : Directed and randomized checks of dm_sram_responder against a
//            queue/array based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_sram_responder;

   localparam int M  = 16384;
   localparam int FD = 8;
   localparam logic [13:0] A_LO   = 14'(M - 4);
   localparam logic [13:0] A_HI   = 14'(M - 3);
   localparam logic [13:0] A_CON  = 14'(M - 2);
   localparam logic [13:0] A_HALT = 14'(M - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        oe;
   logic [13:0] a;
   logic [3:0]  web;
   logic [31:0] di;
   logic [31:0] dm_do;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        rdy;
   logic        halt_o;
   logic [31:0] halt_code_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [63:0] cyc_m;
   logic [31:0] shadow_m;
   logic [31:0] mem_m [16];
   logic [7:0]  fifo_q [$];
   logic        ovf_m;
   logic        halt_m;
   logic [31:0] code_m;

   logic [31:0] last_do;
   logic [7:0]  last_cd;
   logic        last_cv;

   dm_sram_responder #(.DM_DEPTH(M), .FIFO_DEPTH(FD), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .DM_OE(oe), .DM_A(a), .DM_WEB(web), .DM_DI(di),
      .DM_DO(dm_do), .con_valid(con_valid), .con_data(con_data),
      .con_ready(rdy), .halt_o(halt_o), .halt_code_o(halt_code_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set(input logic o, input logic [13:0] ad, input logic [3:0] w,
                      input logic [31:0] d, input logic r);
      oe = o; a = ad; web = w; di = d; rdy = r;
   endtask

   task automatic model_reset();
      cyc_m = '0; shadow_m = '0; fifo_q.delete(); ovf_m = 1'b0;
      halt_m = 1'b0; code_m = '0;
   endtask

   // One clock: check outputs against the model, advance the model, cross the edge.
   task automatic step();
      logic [31:0] exp_do;
      int          n;
      logic        full_pre, pop, wrc;
      #1;
      n = fifo_q.size();
      exp_do = '0;
      if (oe) begin
         if (a < A_LO)        exp_do = mem_m[a[3:0]];
         else if (a == A_LO)  exp_do = cyc_m[31:0];
         else if (a == A_HI)  exp_do = shadow_m;
         else if (a == A_CON) exp_do = {16'h0, 8'(n), 5'b0, ovf_m, (n == 0), (n == FD)};
         else                 exp_do = {31'b0, halt_m};
      end
      chk("dm_do", dm_do, exp_do);
      chk("con_valid", {31'b0, con_valid}, {31'b0, (n != 0)});
      chk("con_data", {24'h0, con_data}, {24'h0, (n != 0) ? fifo_q[0] : 8'h00});
      chk("halt_o", {31'b0, halt_o}, {31'b0, halt_m});
      chk("halt_code", halt_code_o, code_m);
      last_do = dm_do; last_cd = con_data; last_cv = con_valid;

      full_pre = (n == FD);
      pop      = (n != 0) && rdy;
      wrc      = (a == A_CON) && !web[0];
      if (pop) void'(fifo_q.pop_front());
      if (oe && a == A_CON) ovf_m = 1'b0;
      if (wrc) begin
         if (!full_pre || pop) fifo_q.push_back(di[7:0]);
         else ovf_m = 1'b1;
      end
      if (a < A_LO) begin
         for (int i = 0; i < 4; i++)
            if (!web[i]) mem_m[a[3:0]][8*i +: 8] = di[8*i +: 8];
      end
      if (oe && a == A_LO) shadow_m = cyc_m[63:32];
      cyc_m = cyc_m + 64'd1;
      if (a == A_HALT && web != 4'hF && !halt_m) begin
         halt_m = 1'b1;
         code_m = di;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d1;
      rst = 1'b0;
      set(0, 0, 4'hF, 0, 0);
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_con_valid", {31'b0, con_valid}, 32'h0);
      chk("rst_con_data", {24'h0, con_data}, 32'h0);
      chk("rst_halt_o", {31'b0, halt_o}, 32'h0);
      chk("rst_halt_code", halt_code_o, 32'h0);
      oe = 1'b1; a = A_CON; #1;
      chk("rst_status", dm_do, 32'h0000_0002);
      oe = 1'b0;
      rst = 1'b1;

      // RAM byte lanes
      set(0, 5, 4'h0, 32'hAABB_CCDD, 0); step();
      set(0, 5, 4'hE, 32'h0000_0011, 0); step();
      set(0, 5, 4'hF, 32'h0, 0);         step();
      set(1, 5, 4'hF, 32'h0, 0);         step();
      chk("ram_lanes", last_do, 32'hAABB_CC11);

      // Read during write returns old data
      set(0, 7, 4'h0, 32'h1, 0); step();
      set(1, 7, 4'h0, 32'h2, 0); step();
      chk("rdw_old", last_do, 32'h1);
      set(1, 7, 4'hF, 32'h0, 0); step();
      chk("rdw_new", last_do, 32'h2);

      // FIFO fill and overflow
      for (int i = 0; i < 9; i++) begin
         set(0, A_CON, 4'h0, 32'h41 + i, 0); step();
      end
      set(1, A_CON, 4'hF, 0, 0); step();
      chk("fifo_full_ovf", last_do, 32'h0000_0805);
      step();
      chk("fifo_ovf_clr", last_do, 32'h0000_0801);
      for (int i = 0; i < 8; i++) begin
         set(0, 0, 4'hF, 0, 1); step();
         chk("drain_seq", {24'h0, last_cd}, 32'h41 + i);
      end
      set(1, A_CON, 4'hF, 0, 0); step();
      chk("drain_empty", last_do, 32'h0000_0002);
      chk("drain_valid", {31'b0, last_cv}, 32'h0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         set(0, A_CON, 4'h0, 32'h30 + i, 0); step();
      end
      set(0, A_CON, 4'h0, 32'h5A, 1); step();
      set(1, A_CON, 4'hF, 0, 0); step();
      chk("full_pushpop", last_do, 32'h0000_0801);
      for (int i = 0; i < 8; i++) begin
         set(0, 0, 4'hF, 0, 1); step();
         chk("pushpop_seq", {24'h0, last_cd}, (i < 7) ? 32'h31 + i : 32'h5A);
      end

      // Randomized traffic over RAM words 0..15, counter and console
      for (int i = 0; i < 16; i++) begin
         set(0, 14'(i), 4'h0, $urandom, 0); step();
      end
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [13:0] ra;
         r = int'($urandom_range(0, 19));
         if (r < 16)       ra = 14'(r);
         else if (r == 16) ra = A_LO;
         else if (r == 17) ra = A_HI;
         else              ra = A_CON;
         set(1'($urandom), ra, 4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
         step();
      end

      // Halt: first write wins
      set(0, A_HALT, 4'h0, 32'h1, 0);         step();
      set(0, A_HALT, 4'h0, 32'h0000_DEAD, 0); step();
      set(1, A_HALT, 4'hF, 0, 0);             step();
      chk("halt_read", last_do, 32'h1);
      chk("halt_o_set", {31'b0, halt_o}, 32'h1);
      chk("halt_code_first", halt_code_o, 32'h1);
      set(1, A_LO, 4'hF, 0, 0); step();
      d1 = last_do;
      step();
      chk("cyc_runs_after_halt", last_do, d1 + 32'd1);

      // Coherent high-half snapshot across the 32-bit carry
      force dut.r_cyc = 64'h0000_0000_FFFF_FFFF;
      cyc_m = 64'h0000_0000_FFFF_FFFF;
      set(1, A_LO, 4'hF, 0, 0);
      #1;
      release dut.r_cyc;
      step();
      chk("snap_lo", last_do, 32'hFFFF_FFFF);
      set(1, A_HI, 4'hF, 0, 0); step();
      chk("snap_hi", last_do, 32'h0);

      // Asynchronous reset mid-run
      set(0, A_CON, 4'h0, 32'h77, 0); step();
      rst = 1'b0;
      set(1, A_LO, 4'hF, 0, 0);
      #1;
      chk("mid_rst_lo", dm_do, 32'h0);
      a = A_HI; #1;
      chk("mid_rst_hi", dm_do, 32'h0);
      chk("mid_rst_valid", {31'b0, con_valid}, 32'h0);
      chk("mid_rst_halt", {31'b0, halt_o}, 32'h0);
      chk("mid_rst_code", halt_code_o, 32'h0);
      model_reset();
      rst = 1'b1;
      step();
      set(1, A_LO, 4'hF, 0, 0); step();
      chk("post_rst_cyc", last_do, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
